// File: rtl/core_pkg.sv
// Shared RV64I core definitions: memory opcodes, funct3 encodings, LSU state encoding.
// No logic; alignment helper is purely combinational.
// No flow control.
package core_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;
    localparam logic [2:0] F3_SD = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        DONE
    } lsu_state_t;

    // funct3[1:0] encodes log2(access bytes) for both loads and stores.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = offset[0];
            2'd2:    is_misaligned = |offset[1:0];
            default: is_misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane placement for stores and lane extraction plus sign/zero extension for loads.
// Combinational, zero latency.
// No flow control.
module lsu_align
    import core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_ext
);

    logic [7:0]      size_mask;
    logic [XLEN-1:0] shifted;

    always_comb begin
        size_mask = 8'hFF;
        case (funct3[1:0])
            F3_SB[1:0]: size_mask = 8'h01;
            F3_SH[1:0]: size_mask = 8'h03;
            F3_SW[1:0]: size_mask = 8'h0F;
            default:    size_mask = 8'hFF;
        endcase
        wstrb = size_mask << offset;
        wdata = store_data << {offset, 3'b000};
    end

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        load_ext = shifted;
        case (funct3)
            F3_LB:   load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   load_ext = shifted;
            F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LWU:  load_ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64I load/store stage: single-outstanding request/ready access to the data bus.
// Latency: done 3 cycles after start with immediate mem_ready, 1 cycle for faults/non-memory ops.
// Backpressure: mem_req held with stable address/data until mem_ready or MAX_WAIT timeout; start ignored while busy.
module load_store_unit
    import core_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0,
    parameter int          XLEN     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            illegal,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t state_q, state_d;

    logic [31:0]     wait_cnt;
    logic [6:0]      op_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] sdata_q;
    logic [XLEN-1:0] rdata_q;

    logic [6:0] in_op;
    logic [2:0] in_f3;
    logic       in_load, in_store, in_illegal, in_misal, go_access;
    logic       load_q, store_q, in_access, timeout_hit;

    logic [7:0]      align_wstrb;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_load;

    // Only opcode and funct3 matter here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

    assign in_op      = instruction[6:0];
    assign in_f3      = instruction[14:12];
    assign in_load    = (in_op == OP_LOAD);
    assign in_store   = (in_op == OP_STORE);
    assign in_illegal = (in_load && in_f3 == 3'd7) || (in_store && in_f3 > F3_SD);
    assign in_misal   = (in_load || in_store) && is_misaligned(in_f3[1:0], addr[2:0]);
    assign go_access  = (in_load || in_store) && !in_illegal && !in_misal;

    assign load_q      = (op_q == OP_LOAD);
    assign store_q     = (op_q == OP_STORE);
    assign in_access   = (state_q == ACCESS);
    // MAX_WAIT==0 disables the timeout entirely.
    assign timeout_hit = (MAX_WAIT != 0) && (wait_cnt == 32'(MAX_WAIT - 1));

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (f3_q),
        .offset     (addr_q[2:0]),
        .store_data (sdata_q),
        .rdata      (rdata_q),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_ext   (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = go_access ? ACCESS : DONE;
            ACCESS: begin
                if (mem_ready)        state_d = RESP;
                else if (timeout_hit) state_d = DONE;
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            op_q       <= '0;
            f3_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            rdata_q    <= '0;
            load_data  <= '0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q       <= in_op;
                    f3_q       <= in_f3;
                    addr_q     <= addr;
                    sdata_q    <= store_data;
                    misaligned <= in_misal;
                    illegal    <= in_illegal;
                    bus_err    <= 1'b0;
                    wait_cnt   <= '0;
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (load_q) rdata_q <= mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                        if (timeout_hit) bus_err <= 1'b1;
                    end
                end
                RESP: if (load_q) load_data <= align_load;
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_req   = in_access;
    assign mem_we    = in_access && store_q;
    assign mem_addr  = in_access ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign mem_wstrb = (in_access && store_q) ? align_wstrb : '0;
    assign mem_wdata = (in_access && store_q) ? align_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit with MAX_WAIT=4.
module tb_load_store_unit;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [31:0] instruction = '0;
    logic [63:0] addr = '0;
    logic [63:0] store_data = '0;
    logic        busy, done, misaligned, illegal, bus_err;
    logic [63:0] load_data;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.MAX_WAIT(MAX_WAIT), .XLEN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instruction (instruction),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        string       tag;
        logic [63:0] load_data;
        logic        mis;
        logic        ill;
        logic        berr;
        int          lat;
        logic        req;
        logic        we;
        logic [63:0] maddr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    function automatic exp_t mk(input string tag, input logic [63:0] ld, input logic mis, input logic ill,
                                input logic berr, input int lat, input logic req, input logic we,
                                input logic [63:0] maddr, input logic [7:0] wstrb, input logic [63:0] wdata);
        exp_t e;
        e.tag = tag; e.load_data = ld; e.mis = mis; e.ill = ill; e.berr = berr; e.lat = lat;
        e.req = req; e.we = we; e.maddr = maddr; e.wstrb = wstrb; e.wdata = wdata;
        return e;
    endfunction

    // Drives one instruction, watches the bus, and compares against the queued expectation at done.
    task automatic run_op(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] sd,
                          input logic [63:0] rd, input logic rdy, input logic poke_busy, input exp_t e);
        exp_t        x;
        int          lat;
        logic        seen;
        logic        s_we;
        logic [63:0] s_addr, s_wdata;
        logic [7:0]  s_wstrb;
        sb.push_back(e);
        lat = 0; seen = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        @(negedge clk);
        instruction = ins; addr = a; store_data = sd; mem_rdata = rd; mem_ready = rdy; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (poke_busy && c == 2);
            if (c == 1) check({e.tag, "/busy"}, 64'(busy), 64'd1);
            if (mem_req && !seen) begin
                seen = 1'b1; s_we = mem_we; s_addr = mem_addr; s_wstrb = mem_wstrb; s_wdata = mem_wdata;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        x = sb.pop_front();
        check({x.tag, "/latency"}, 64'(lat), 64'(x.lat));
        check({x.tag, "/load_data"}, load_data, x.load_data);
        check({x.tag, "/misaligned"}, 64'(misaligned), 64'(x.mis));
        check({x.tag, "/illegal"}, 64'(illegal), 64'(x.ill));
        check({x.tag, "/bus_err"}, 64'(bus_err), 64'(x.berr));
        check({x.tag, "/mem_req_seen"}, 64'(seen), 64'(x.req));
        if (x.req) begin
            check({x.tag, "/mem_we"}, 64'(s_we), 64'(x.we));
            check({x.tag, "/mem_addr"}, s_addr, x.maddr);
            check({x.tag, "/mem_wstrb"}, 64'(s_wstrb), 64'(x.wstrb));
            check({x.tag, "/mem_wdata"}, s_wdata, x.wdata);
        end
        @(negedge clk);
        check({x.tag, "/done_one_cycle"}, 64'(done), 64'd0);
        check({x.tag, "/idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/mem_req", 64'(mem_req), 64'd0);
        check("reset/load_data", load_data, 64'd0);
        check("reset/flags", {61'd0, misaligned, illegal, bus_err}, 64'd0);
        rst_n = 1'b1;

        run_op(32'h0000_0003, 64'h1003, 64'h0, 64'h00000000_80000000, 1'b1, 1'b0,
               mk("lb", 64'hFFFFFFFF_FFFFFF80, 0, 0, 0, 3, 1, 0, 64'h1000, 8'h00, 64'h0));
        run_op(32'h0000_6003, 64'h2004, 64'h0, 64'hDEADBEEF_00000000, 1'b1, 1'b0,
               mk("lwu", 64'h00000000_DEADBEEF, 0, 0, 0, 3, 1, 0, 64'h2000, 8'h00, 64'h0));
        run_op(32'h0000_1023, 64'h3006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               mk("sh", 64'h00000000_DEADBEEF, 0, 0, 0, 3, 1, 1, 64'h3000, 8'hC0, 64'h1234_0000_0000_0000));
        run_op(32'h0000_3003, 64'h4004, 64'h0, 64'h0, 1'b1, 1'b0,
               mk("ld_misal", 64'h00000000_DEADBEEF, 1, 0, 0, 1, 0, 0, 64'h0, 8'h00, 64'h0));
        run_op(32'h0000_3003, 64'h5000, 64'h0, 64'h0, 1'b0, 1'b1,
               mk("ld_timeout", 64'h00000000_DEADBEEF, 0, 0, 1, 5, 1, 0, 64'h5000, 8'h00, 64'h0));
        run_op(32'h0000_1003, 64'h6002, 64'h0, 64'h00000000_80010000, 1'b1, 1'b0,
               mk("lh", 64'hFFFFFFFF_FFFF8001, 0, 0, 0, 3, 1, 0, 64'h6000, 8'h00, 64'h0));
        run_op(32'h0000_4003, 64'h8007, 64'h0, 64'hAB000000_00000000, 1'b1, 1'b0,
               mk("lbu", 64'h00000000_000000AB, 0, 0, 0, 3, 1, 0, 64'h8000, 8'h00, 64'h0));
        run_op(32'h0000_2003, 64'h9000, 64'h0, 64'h00000000_80000000, 1'b1, 1'b0,
               mk("lw", 64'hFFFFFFFF_80000000, 0, 0, 0, 3, 1, 0, 64'h9000, 8'h00, 64'h0));
        run_op(32'h0000_0013, 64'h9001, 64'h0, 64'h0, 1'b1, 1'b0,
               mk("addi", 64'hFFFFFFFF_80000000, 0, 0, 0, 1, 0, 0, 64'h0, 8'h00, 64'h0));
        run_op(32'h0000_5023, 64'h7000, 64'h0, 64'h0, 1'b1, 1'b0,
               mk("store_f3_5", 64'hFFFFFFFF_80000000, 0, 1, 0, 1, 0, 0, 64'h0, 8'h00, 64'h0));
        run_op(32'h0000_7003, 64'h7001, 64'h0, 64'h0, 1'b1, 1'b0,
               mk("load_f3_7", 64'hFFFFFFFF_80000000, 1, 1, 0, 1, 0, 0, 64'h0, 8'h00, 64'h0));

        // Asynchronous reset in the middle of a stalled access.
        @(negedge clk);
        instruction = 32'h0000_3003; addr = 64'hB000; mem_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid/req_before", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/mem_req", 64'(mem_req), 64'd0);
        check("rst_mid/busy", 64'(busy), 64'd0);
        check("rst_mid/mem_addr", mem_addr, 64'd0);
        check("rst_mid/load_data", load_data, 64'd0);
        check("rst_mid/flags", {60'd0, done, misaligned, illegal, bus_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_3023, 64'hA000, 64'h01020304_05060708, 64'h0, 1'b1, 1'b0,
               mk("sd", 64'h0, 0, 0, 0, 3, 1, 1, 64'hA000, 8'hFF, 64'h01020304_05060708));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
